// File: rtl/remote_cmd_if_if.sv
// Parallel side of the remote UART front end: the decoded command frame goes out
// and the response byte comes in from the command-configuration stage.
interface remote_cmd_if_if;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        tx_busy;
    logic        resp_sent;

    modport master (
        output clr_cmd_rdy, resp, send_resp,
        input  cmd_rdy, cmd, data, tx_busy, resp_sent
    );

    modport slave (
        input  clr_cmd_rdy, resp, send_resp,
        output cmd_rdy, cmd, data, tx_busy, resp_sent
    );
endinterface

// File: rtl/remote_cmd_if.sv
// UART front end for the flight controller: assembles 3-byte command frames from RX
// and serialises the 1-byte response onto TX, full duplex with independent baud timers.
module remote_cmd_if #(
    parameter int BAUD_DIV = 2604
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           RX,
    output logic           TX,
    remote_cmd_if_if.slave host
);
    localparam int CW = $clog2(BAUD_DIV) + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(BAUD_DIV);
    localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic       {RX_IDLE, RX_RECV}            rx_state_t;
    typedef enum logic [1:0] {WAIT_CMD, WAIT_HI, WAIT_LO}  asm_state_t;
    typedef enum logic       {TX_IDLE, TX_XMIT}            tx_state_t;

    logic          rx_meta_reg, rx_sync_reg, rx_prev_reg;
    logic          rx_start;
    rx_state_t     rx_state_reg, rx_state_next;
    logic [CW-1:0] rx_cnt_reg, rx_cnt_next;
    logic [3:0]    rx_bit_reg, rx_bit_next;
    logic [9:0]    rx_shift_reg, rx_shift_next;
    logic          rx_done_reg, rx_done_next;
    logic          rx_byte_vld, rx_frame_err;

    asm_state_t    asm_state_reg, asm_state_next;
    logic [7:0]    cmd_reg, cmd_next;
    logic [15:0]   data_reg, data_next;
    logic          cmd_rdy_reg, cmd_rdy_next;
    logic          frame_set;

    tx_state_t     tx_state_reg, tx_state_next;
    logic [CW-1:0] tx_cnt_reg, tx_cnt_next;
    logic [3:0]    tx_bit_reg, tx_bit_next;
    logic [9:0]    tx_shift_reg, tx_shift_next;
    logic          resp_sent_reg, resp_sent_next;

    // RX passes two flops before use; the third only exists for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= RX;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
        end
    end

    assign rx_start = (rx_state_reg == RX_IDLE) && rx_prev_reg && !rx_sync_reg;

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        rx_done_next  = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                if (rx_start) begin
                    rx_state_next = RX_RECV;
                    rx_cnt_next   = CNT_HALF;
                    rx_bit_next   = 4'd0;
                end
            end
            RX_RECV: begin
                if (rx_cnt_reg == CNT_ONE) begin
                    rx_shift_next = {rx_sync_reg, rx_shift_reg[9:1]};
                    rx_cnt_next   = CNT_FULL;
                    rx_bit_next   = rx_bit_reg + 4'd1;
                    if (rx_bit_reg == 4'd0 && rx_sync_reg) begin
                        rx_state_next = RX_IDLE;
                    end else if (rx_bit_reg == 4'd9) begin
                        rx_state_next = RX_IDLE;
                        rx_done_next  = 1'b1;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg - CNT_ONE;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_reg <= RX_IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= 4'd0;
            rx_shift_reg <= 10'h3FF;
            rx_done_reg  <= 1'b0;
        end else begin
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_bit_reg   <= rx_bit_next;
            rx_shift_reg <= rx_shift_next;
            rx_done_reg  <= rx_done_next;
        end
    end

    // After the 10th sample the register holds {stop, data[7:0], start}.
    assign rx_byte_vld  = rx_done_reg && rx_shift_reg[9] && !rx_shift_reg[0];
    assign rx_frame_err = rx_done_reg && !rx_byte_vld;

    always_comb begin
        asm_state_next = asm_state_reg;
        cmd_next       = cmd_reg;
        data_next      = data_reg;
        frame_set      = 1'b0;
        if (rx_frame_err) begin
            asm_state_next = WAIT_CMD;
        end else if (rx_byte_vld) begin
            case (asm_state_reg)
                WAIT_CMD: begin
                    cmd_next       = rx_shift_reg[8:1];
                    asm_state_next = WAIT_HI;
                end
                WAIT_HI: begin
                    data_next[15:8] = rx_shift_reg[8:1];
                    asm_state_next  = WAIT_LO;
                end
                WAIT_LO: begin
                    data_next[7:0] = rx_shift_reg[8:1];
                    asm_state_next = WAIT_CMD;
                    frame_set      = 1'b1;
                end
                default: asm_state_next = WAIT_CMD;
            endcase
        end
        // A completed frame outranks a simultaneous knock-down.
        cmd_rdy_next = frame_set ||
                       (cmd_rdy_reg && !host.clr_cmd_rdy &&
                        !(rx_start && asm_state_reg == WAIT_CMD));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_state_reg <= WAIT_CMD;
            cmd_reg       <= 8'h00;
            data_reg      <= 16'h0000;
            cmd_rdy_reg   <= 1'b0;
        end else begin
            asm_state_reg <= asm_state_next;
            cmd_reg       <= cmd_next;
            data_reg      <= data_next;
            cmd_rdy_reg   <= cmd_rdy_next;
        end
    end

    // TX line is bit 0 of the shift register; ones refill from the top so idle reads high.
    always_comb begin
        tx_state_next  = tx_state_reg;
        tx_cnt_next    = tx_cnt_reg;
        tx_bit_next    = tx_bit_reg;
        tx_shift_next  = tx_shift_reg;
        resp_sent_next = 1'b0;
        case (tx_state_reg)
            TX_IDLE: begin
                if (host.send_resp) begin
                    tx_state_next = TX_XMIT;
                    tx_shift_next = {1'b1, host.resp, 1'b0};
                    tx_cnt_next   = CNT_FULL;
                    tx_bit_next   = 4'd0;
                end
            end
            TX_XMIT: begin
                if (tx_cnt_reg == CNT_ONE) begin
                    tx_cnt_next = CNT_FULL;
                    if (tx_bit_reg == 4'd9) begin
                        tx_state_next  = TX_IDLE;
                        resp_sent_next = 1'b1;
                    end else begin
                        tx_shift_next = {1'b1, tx_shift_reg[9:1]};
                        tx_bit_next   = tx_bit_reg + 4'd1;
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg - CNT_ONE;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_reg  <= TX_IDLE;
            tx_cnt_reg    <= '0;
            tx_bit_reg    <= 4'd0;
            tx_shift_reg  <= 10'h3FF;
            resp_sent_reg <= 1'b0;
        end else begin
            tx_state_reg  <= tx_state_next;
            tx_cnt_reg    <= tx_cnt_next;
            tx_bit_reg    <= tx_bit_next;
            tx_shift_reg  <= tx_shift_next;
            resp_sent_reg <= resp_sent_next;
        end
    end

    assign TX             = tx_shift_reg[0];
    assign host.tx_busy   = (tx_state_reg == TX_XMIT);
    assign host.resp_sent = resp_sent_reg;
    assign host.cmd_rdy   = cmd_rdy_reg;
    assign host.cmd       = cmd_reg;
    assign host.data      = data_reg;
endmodule

// File: tb/tb_remote_cmd_if.sv
// Directed bench for remote_cmd_if at 16 clk/bit: frames and responses are queued as
// they are driven and checked when cmd_rdy rises or a TX byte completes.
module tb_remote_cmd_if;
    localparam int BD     = 16;
    localparam int CLK_NS = 10;
    localparam int RDY_LAT = 156;  // 3rd start-bit drive to cmd_rdy: 2 sync + 1 edge + 8 half-bit + 9*16 + 1

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic RX = 1'b1;
    logic TX;

    remote_cmd_if_if bus ();

    remote_cmd_if #(.BAUD_DIV(BD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .RX    (RX),
        .TX    (TX),
        .host  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [23:0] frame_q[$];
    logic [7:0]  tx_q[$];
    time t_byte_start = 0;
    time t_frame_start = 0;
    time t_fall = 0;
    logic rdy_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_wave(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bits(input logic [9:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            RX = bits[i];
            if (i == 0) t_byte_start = $time;
            repeat (BD - 1) @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        drive_bits({stop, b, 1'b0}, 10);
        if (!stop) begin
            @(negedge clk);
            RX = 1'b1;
            repeat (BD) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [15:0] d);
        frame_q.push_back({c, d});
        send_byte(c, 1'b1);
        t_frame_start = t_byte_start;
        send_byte(d[15:8], 1'b1);
        send_byte(d[7:0], 1'b1);
    endtask

    task automatic pulse_send(input logic [7:0] b, input logic expect_tx);
        @(negedge clk);
        bus.resp = b;
        bus.send_resp = 1'b1;
        if (expect_tx) tx_q.push_back(b);
        @(negedge clk);
        bus.send_resp = 1'b0;
    endtask

    // Frame scoreboard: every cmd_rdy rise must match the oldest driven frame.
    always @(negedge clk) begin
        if (!rst_n) begin
            rdy_prev = 1'b0;
        end else begin
            if (bus.cmd_rdy && !rdy_prev) begin
                check("frame_expected", 32'(frame_q.size() != 0), 1);
                if (frame_q.size() != 0) begin
                    logic [23:0] f;
                    f = frame_q.pop_front();
                    check("frame_cmd", 32'(bus.cmd), 32'(f[23:16]));
                    check("frame_data", 32'(bus.data), 32'(f[15:0]));
                    check("frame_latency", 32'(($time - t_byte_start) / CLK_NS), RDY_LAT);
                end
            end
            if (!bus.cmd_rdy && rdy_prev) t_fall = $time;
            rdy_prev = bus.cmd_rdy;
        end
    end

    // TX scoreboard: capture the whole 160-clk waveform of each byte and its tail.
    initial begin : tx_mon
        logic tx_prev;
        logic [159:0] obs_wave, exp_wave;
        logic [9:0] fr;
        logic [7:0] b;
        logic aborted, busy_all, sent_seen;
        tx_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && tx_prev && !TX) begin
                check("tx_expected", 32'(tx_q.size() != 0), 1);
                b = (tx_q.size() != 0) ? tx_q.pop_front() : 8'h00;
                fr = {1'b1, b, 1'b0};
                aborted = 1'b0;
                busy_all = 1'b1;
                sent_seen = 1'b0;
                for (int k = 0; k < 160; k++) begin
                    if (k > 0) @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    obs_wave[k] = TX;
                    exp_wave[k] = fr[k / BD];
                    busy_all = busy_all & bus.tx_busy;
                    sent_seen = sent_seen | bus.resp_sent;
                end
                if (!aborted) begin
                    check_wave("tx_wave", obs_wave, exp_wave);
                    check("tx_busy_during", 32'(busy_all), 1);
                    check("resp_sent_early", 32'(sent_seen), 0);
                    @(negedge clk);
                    check("tx_idle_after", 32'(TX), 1);
                    check("tx_busy_after", 32'(bus.tx_busy), 0);
                    check("resp_sent_pulse", 32'(bus.resp_sent), 1);
                    @(negedge clk);
                    check("resp_sent_single", 32'(bus.resp_sent), 0);
                end
            end
            tx_prev = TX;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.clr_cmd_rdy = 1'b0;
        bus.resp = 8'h00;
        bus.send_resp = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(TX), 1);
        check("rst_cmd_rdy", 32'(bus.cmd_rdy), 0);
        check("rst_cmd", 32'(bus.cmd), 'h00);
        check("rst_data", 32'(bus.data), 'h0000);
        check("rst_tx_busy", 32'(bus.tx_busy), 0);
        check("rst_resp_sent", 32'(bus.resp_sent), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Basic frame, hold, then knock-down.
        send_frame(8'h02, 16'h1234);
        repeat (20) @(negedge clk);
        check("t1_rdy_hold", 32'(bus.cmd_rdy), 1);
        bus.clr_cmd_rdy = 1'b1;
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b0;
        check("t1_rdy_clr", 32'(bus.cmd_rdy), 0);
        check("t1_cmd_kept", 32'(bus.cmd), 'h02);
        check("t1_data_kept", 32'(bus.data), 'h1234);

        // clr_cmd_rdy held through the set cycle: the rise still happens, then clears.
        bus.clr_cmd_rdy = 1'b1;
        send_frame(8'h33, 16'h4455);
        check("set_wins_then_clr", 32'(bus.cmd_rdy), 0);
        bus.clr_cmd_rdy = 1'b0;
        repeat (5) @(negedge clk);

        // Response byte; extra requests mid-byte and on the final clk are dropped.
        pulse_send(8'hA5, 1'b1);
        repeat (49) @(negedge clk);
        bus.resp = 8'h3C;
        bus.send_resp = 1'b1;
        @(negedge clk);
        bus.send_resp = 1'b0;
        repeat (108) @(negedge clk);
        bus.send_resp = 1'b1;
        @(negedge clk);
        bus.send_resp = 1'b0;
        repeat (200) @(negedge clk);
        check("tx_no_extra_busy", 32'(bus.tx_busy), 0);
        check("tx_no_extra_line", 32'(TX), 1);

        // Unacknowledged frame is knocked down by the next start edge.
        send_frame(8'h05, 16'h0100);
        repeat (10) @(negedge clk);
        check("t3_cmd_stable", 32'(bus.cmd), 'h05);
        t_fall = 0;
        send_frame(8'h06, 16'h0708);
        check("t3_fall_at_start", 32'((t_fall - t_frame_start) / CLK_NS), 3);
        check("t3_cmd", 32'(bus.cmd), 'h06);
        check("t3_rdy", 32'(bus.cmd_rdy), 1);

        // Framing error in the middle byte abandons the frame.
        send_byte(8'h09, 1'b1);
        send_byte(8'hAA, 1'b0);
        check("t4_no_rdy", 32'(bus.cmd_rdy), 0);
        check("t4_data_kept", 32'(bus.data), 'h0708);
        send_frame(8'h08, 16'h0000);
        check("t4_cmd", 32'(bus.cmd), 'h08);
        check("t4_rdy", 32'(bus.cmd_rdy), 1);
        bus.clr_cmd_rdy = 1'b1;
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b0;

        // Short low glitch on an idle line.
        @(negedge clk);
        RX = 1'b0;
        repeat (4) @(negedge clk);
        RX = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_cmd", 32'(bus.cmd), 'h08);
        check("glitch_rdy", 32'(bus.cmd_rdy), 0);

        // Reset in the middle of an RX byte and a TX byte.
        send_byte(8'h21, 1'b1);
        pulse_send(8'h5A, 1'b1);
        drive_bits({1'b1, 8'h43, 1'b0}, 5);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", 32'(TX), 1);
        check("mid_rst_busy", 32'(bus.tx_busy), 0);
        check("mid_rst_rdy", 32'(bus.cmd_rdy), 0);
        check("mid_rst_cmd", 32'(bus.cmd), 'h00);
        @(negedge clk);
        RX = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h7E, 16'hBEEF);
        check("post_rst_cmd", 32'(bus.cmd), 'h7E);
        check("post_rst_data", 32'(bus.data), 'hBEEF);

        // Full duplex: response byte and command frame at the same time.
        fork
            send_frame(8'hC3, 16'h5AA5);
            pulse_send(8'hA5, 1'b1);
        join
        repeat (30) @(negedge clk);
        check("duplex_cmd", 32'(bus.cmd), 'hC3);
        check("duplex_data", 32'(bus.data), 'h5AA5);
        check("frame_q_drained", 32'(frame_q.size()), 0);
        check("tx_q_drained", 32'(tx_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
